// File: rtl/instr_feeder.sv
`default_nettype none
// ============================================================================
// Module   : instr_feeder
// Brief    : Serially loaded program memory that replays its contents onto
//            the core's 6-bit instr bus, one word per cycle, inserting a NOP
//            bubble and redirecting on a taken conditional jump.
// Revision : 1.0 - initial release
// ============================================================================
module instr_feeder #(
    parameter int          DEPTH     = 16,
    parameter logic [5:0]  NOP       = 6'b000000,
    parameter int          MAX_STEPS = 255,
    localparam int         AW        = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           rst,        // asynchronous, active-low
    input  logic           load_en,
    input  logic [5:0]     load_data,
    input  logic           clear,
    input  logic           start,
    input  logic           loop_en,
    input  logic           stop,
    input  logic [AW-1:0]  jump_addr,
    input  logic           cjump,
    output logic [5:0]     instr,
    output logic           busy,
    output logic           done,
    output logic           timeout,
    output logic           load_ovf
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW:0] c_depth     = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_one       = (AW+1)'(1);
    localparam logic [7:0]  c_max_steps = 8'(MAX_STEPS);

    state_t      r_state, w_state_nxt;
    logic [AW:0] r_pc,    w_pc_nxt;
    logic [AW:0] r_len,   w_len_nxt;
    logic [AW:0] r_wptr,  w_wptr_nxt;
    logic [7:0]  r_steps, w_steps_nxt;
    logic [5:0]  r_instr, w_instr_nxt;
    logic        r_timeout, w_timeout_nxt;
    logic        r_load_ovf, w_load_ovf_nxt;
    logic        r_busy, r_done;
    logic        w_mem_we;

    logic [5:0]  r_mem [DEPTH];
    logic [5:0]  w_mem_first;
    logic [5:0]  w_mem_at_pc;

    // pc only indexes memory when pc < len <= DEPTH, so the low AW bits suffice
    assign w_mem_first = r_mem[0];
    assign w_mem_at_pc = r_mem[r_pc[AW-1:0]];

    // Next-state and next-register decode; every register holds by default
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_len_nxt      = r_len;
        w_wptr_nxt     = r_wptr;
        w_steps_nxt    = r_steps;
        w_instr_nxt    = r_instr;
        w_timeout_nxt  = r_timeout;
        w_load_ovf_nxt = r_load_ovf;
        w_mem_we       = 1'b0;

        case (r_state)
            S_IDLE: begin
                // clear beats load, and a load in the same cycle swallows start
                if (clear) begin
                    w_wptr_nxt     = '0;
                    w_len_nxt      = '0;
                    w_load_ovf_nxt = 1'b0;
                end else if (load_en) begin
                    if (r_wptr < c_depth) begin
                        w_mem_we   = 1'b1;
                        w_wptr_nxt = r_wptr + c_one;
                        w_len_nxt  = r_len + c_one;
                    end else begin
                        w_load_ovf_nxt = 1'b1;
                    end
                end else if (start && (r_len != '0)) begin
                    w_instr_nxt   = w_mem_first;
                    w_pc_nxt      = c_one;
                    w_steps_nxt   = 8'd1;
                    w_timeout_nxt = 1'b0;
                    w_state_nxt   = S_RUN;
                end
            end

            S_RUN: begin
                if (stop) begin
                    w_instr_nxt = NOP;
                    w_state_nxt = S_DONE;
                end else if (cjump) begin
                    // bubble cycle: the jump target is fetched on the next edge
                    w_instr_nxt = NOP;
                    w_pc_nxt    = {1'b0, jump_addr};
                end else if (r_steps == c_max_steps) begin
                    w_instr_nxt   = NOP;
                    w_timeout_nxt = 1'b1;
                    w_state_nxt   = S_DONE;
                end else if (r_pc >= r_len) begin
                    if (loop_en) begin
                        w_instr_nxt = w_mem_first;
                        w_pc_nxt    = c_one;
                        w_steps_nxt = r_steps + 8'd1;
                    end else begin
                        w_instr_nxt = NOP;
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_instr_nxt = w_mem_at_pc;
                    w_pc_nxt    = r_pc + c_one;
                    w_steps_nxt = r_steps + 8'd1;
                end
            end

            S_DONE: begin
                w_instr_nxt = NOP;
                if (start) begin
                    w_state_nxt = S_IDLE;
                end
            end

            default: begin
                w_instr_nxt = NOP;
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Control/status registers; status flags track the next state so they stay registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_pc       <= '0;
            r_len      <= '0;
            r_wptr     <= '0;
            r_steps    <= '0;
            r_instr    <= NOP;
            r_timeout  <= 1'b0;
            r_load_ovf <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_len      <= w_len_nxt;
            r_wptr     <= w_wptr_nxt;
            r_steps    <= w_steps_nxt;
            r_instr    <= w_instr_nxt;
            r_timeout  <= w_timeout_nxt;
            r_load_ovf <= w_load_ovf_nxt;
            r_busy     <= (w_state_nxt == S_RUN);
            r_done     <= (w_state_nxt == S_DONE);
        end
    end

    // Program memory write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_wptr[AW-1:0]] <= load_data;
        end
    end

    assign instr    = r_instr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign timeout  = r_timeout;
    assign load_ovf = r_load_ovf;

endmodule
`default_nettype wire

// File: tb/tb_instr_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_feeder
// Brief    : Directed scoreboard bench for instr_feeder; a second instance
//            with a small step limit exercises the runaway-loop guard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_feeder;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en, clear, start, loop_en, stop, cjump;
    logic [5:0] load_data;
    logic [3:0] jump_addr;

    logic [5:0] instr_a, instr_b;
    logic       busy_a, done_a, tmo_a, ovf_a;
    logic       busy_b, done_b, tmo_b, ovf_b;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       sel;     // 0: default instance, 1: MAX_STEPS=7 instance
        logic [5:0] instr;
        logic       busy;
        logic       done;
        logic       tmo;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    instr_feeder dut (
        .clk(clk), .rst(rst), .load_en(load_en), .load_data(load_data),
        .clear(clear), .start(start), .loop_en(loop_en), .stop(stop),
        .jump_addr(jump_addr), .cjump(cjump),
        .instr(instr_a), .busy(busy_a), .done(done_a),
        .timeout(tmo_a), .load_ovf(ovf_a)
    );

    instr_feeder #(.MAX_STEPS(7)) dut7 (
        .clk(clk), .rst(rst), .load_en(load_en), .load_data(load_data),
        .clear(clear), .start(start), .loop_en(loop_en), .stop(stop),
        .jump_addr(jump_addr), .cjump(cjump),
        .instr(instr_b), .busy(busy_b), .done(done_b),
        .timeout(tmo_b), .load_ovf(ovf_b)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic sel, input logic [5:0] i, input logic b,
                        input logic d, input logic t);
        exp_t e;
        e.sel = sel; e.instr = i; e.busy = b; e.done = d; e.tmo = t;
        sb.push_back(e);
    endtask

    // Advance one edge, then retire every expectation queued for that edge
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.sel == 1'b0) begin
                chk({tag, ".instr"}, {2'b0, instr_a}, {2'b0, e.instr});
                chk({tag, ".busy"},  {7'b0, busy_a},  {7'b0, e.busy});
                chk({tag, ".done"},  {7'b0, done_a},  {7'b0, e.done});
                chk({tag, ".tmo"},   {7'b0, tmo_a},   {7'b0, e.tmo});
            end else begin
                chk({tag, ".instr7"}, {2'b0, instr_b}, {2'b0, e.instr});
                chk({tag, ".busy7"},  {7'b0, busy_b},  {7'b0, e.busy});
                chk({tag, ".done7"},  {7'b0, done_b},  {7'b0, e.done});
                chk({tag, ".tmo7"},   {7'b0, tmo_b},   {7'b0, e.tmo});
            end
        end
    endtask

    task automatic load(input logic [5:0] w);
        load_en = 1'b1; load_data = w;
        @(posedge clk); #1;
        load_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
    endtask

    // Return both instances from DONE to IDLE
    task automatic back_to_idle();
        start = 1'b1; loop_en = 1'b0;
        push(1'b0, 6'h00, 1'b0, 1'b0, 1'b0);
        tick("to_idle");
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; load_en = 1'b0; clear = 1'b0; start = 1'b0;
        loop_en = 1'b0; stop = 1'b0; cjump = 1'b0;
        load_data = 6'h00; jump_addr = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.instr", {2'b0, instr_a}, 8'h00);
        chk("rst.busy",  {7'b0, busy_a},  8'h00);
        chk("rst.done",  {7'b0, done_a},  8'h00);
        chk("rst.tmo",   {7'b0, tmo_a},   8'h00);
        chk("rst.ovf",   {7'b0, ovf_a},   8'h00);
        rst = 1'b1;

        // Straight-line program, no loop
        load(6'h11); load(6'h22); load(6'h33);
        start = 1'b1;
        push(1'b0, 6'h11, 1'b1, 1'b0, 1'b0); tick("seq0");
        start = 1'b0;
        push(1'b0, 6'h22, 1'b1, 1'b0, 1'b0); tick("seq1");
        push(1'b0, 6'h33, 1'b1, 1'b0, 1'b0); tick("seq2");
        push(1'b0, 6'h00, 1'b0, 1'b1, 1'b0); tick("seq_end");
        push(1'b0, 6'h00, 1'b0, 1'b1, 1'b0); tick("done_hold");
        back_to_idle();

        // Looping run: the 7-step instance hits its guard, the default one keeps going
        loop_en = 1'b1; start = 1'b1;
        push(1'b1, 6'h11, 1'b1, 1'b0, 1'b0); tick("loop0");
        start = 1'b0;
        push(1'b1, 6'h22, 1'b1, 1'b0, 1'b0); tick("loop1");
        push(1'b1, 6'h33, 1'b1, 1'b0, 1'b0); tick("loop2");
        push(1'b1, 6'h11, 1'b1, 1'b0, 1'b0); push(1'b0, 6'h11, 1'b1, 1'b0, 1'b0); tick("loop3");
        push(1'b1, 6'h22, 1'b1, 1'b0, 1'b0); tick("loop4");
        push(1'b1, 6'h33, 1'b1, 1'b0, 1'b0); tick("loop5");
        push(1'b1, 6'h11, 1'b1, 1'b0, 1'b0); tick("loop6");
        push(1'b1, 6'h00, 1'b0, 1'b1, 1'b1); push(1'b0, 6'h22, 1'b1, 1'b0, 1'b0); tick("loop_tmo");
        stop = 1'b1;
        push(1'b0, 6'h00, 1'b0, 1'b1, 1'b0); push(1'b1, 6'h00, 1'b0, 1'b1, 1'b1); tick("stop");
        stop = 1'b0; loop_en = 1'b0;
        back_to_idle();

        // Taken jump back to address 1 while 03 is on the bus
        do_clear();
        for (int i = 1; i <= 5; i++) load(6'(i));
        start = 1'b1;
        push(1'b0, 6'h01, 1'b1, 1'b0, 1'b0); tick("jmp0");
        start = 1'b0;
        push(1'b0, 6'h02, 1'b1, 1'b0, 1'b0); tick("jmp1");
        push(1'b0, 6'h03, 1'b1, 1'b0, 1'b0); tick("jmp2");
        cjump = 1'b1; jump_addr = 4'd1;
        push(1'b0, 6'h00, 1'b1, 1'b0, 1'b0); tick("jmp_bubble");
        cjump = 1'b0;
        push(1'b0, 6'h02, 1'b1, 1'b0, 1'b0); tick("jmp_tgt");
        push(1'b0, 6'h03, 1'b1, 1'b0, 1'b0); tick("jmp3");
        push(1'b0, 6'h04, 1'b1, 1'b0, 1'b0); tick("jmp4");
        push(1'b0, 6'h05, 1'b1, 1'b0, 1'b0); tick("jmp5");
        // the guard is checked before end-of-program, so the 7-step instance times out here
        push(1'b0, 6'h00, 1'b0, 1'b1, 1'b0); push(1'b1, 6'h00, 1'b0, 1'b1, 1'b1); tick("jmp_end");
        back_to_idle();

        // Back-to-back jumps, last one out of range -> finish
        start = 1'b1;
        push(1'b0, 6'h01, 1'b1, 1'b0, 1'b0); tick("far0");
        start = 1'b0;
        cjump = 1'b1; jump_addr = 4'd3;
        push(1'b0, 6'h00, 1'b1, 1'b0, 1'b0); tick("far_b2b");
        jump_addr = 4'd9;
        push(1'b0, 6'h00, 1'b1, 1'b0, 1'b0); tick("far_bubble");
        cjump = 1'b0;
        push(1'b0, 6'h00, 1'b0, 1'b1, 1'b0); tick("far_end");
        back_to_idle();

        // Overflow on the 17th load, then clear
        do_clear();
        for (int i = 0; i < 16; i++) load(6'(i + 8));
        chk("ovf16", {7'b0, ovf_a}, 8'h00);
        load(6'h3f);
        chk("ovf17", {7'b0, ovf_a}, 8'h01);
        do_clear();
        chk("ovf_clr", {7'b0, ovf_a}, 8'h00);
        start = 1'b1;
        push(1'b0, 6'h00, 1'b0, 1'b0, 1'b0); tick("start_len0");
        start = 1'b0;

        // Asynchronous reset mid-run
        load(6'h2a); load(6'h15);
        start = 1'b1;
        push(1'b0, 6'h2a, 1'b1, 1'b0, 1'b0); tick("arst_run");
        start = 1'b0;
        #3 rst = 1'b0;
        #1;
        chk("arst.instr", {2'b0, instr_a}, 8'h00);
        chk("arst.busy",  {7'b0, busy_a},  8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        start = 1'b1;
        push(1'b0, 6'h00, 1'b0, 1'b0, 1'b0); tick("arst_start");
        start = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
